// File: rtl/dcache_write_buffer_if.sv
// Block-level memory port shared by the cache side and the data-memory side of the write buffer.
// master drives requests; slave returns data and stall.
interface dcache_write_buffer_if;
  logic        read;
  logic        write;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        busywait;

  modport master (output read, write, address, writedata, input  readdata, busywait);
  modport slave  (input  read, write, address, writedata, output readdata, busywait);
endinterface

// File: rtl/dcache_write_buffer.sv
// Posted write buffer between the data cache and data memory: FIFO drain, read forwarding/bypass.
// Optional in-place write coalescing when WBUF_COALESCE_EN is defined.
module dcache_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  dcache_write_buffer_if.slave  mem,
  dcache_write_buffer_if.master dmem,
  output logic                  wbuf_empty
);
`ifdef WBUF_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DRAIN, READ, RDONE} state_t;

  state_t           state, next_state;
  logic [5:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;
  logic [31:0]      rdata_q;
  logic             full, empty;
  logic             fwd_hit, coal_hit, read_hit;
  logic [PTR_W-1:0] fwd_idx, coal_idx;
  logic             coal_write, push, pop;
  logic             start_read, start_drain, read_done;

  assign full  = (count == (PTR_W+1)'(DEPTH));
  assign empty = (count == '0);

  // Walk oldest to youngest so the last match is the youngest copy.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_idx  = '0;
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (((PTR_W+1)'(k) < count) && (addr_q[head + PTR_W'(k)] == mem.address)) begin
        fwd_hit = 1'b1;
        fwd_idx = head + PTR_W'(k);
        if (!(k == 0 && state == DRAIN)) begin
          coal_hit = 1'b1;
          coal_idx = head + PTR_W'(k);
        end
      end
    end
  end

  assign read_hit   = mem.read & fwd_hit;
  assign coal_write = COALESCE & mem.write & ~mem.read & coal_hit;
  assign push       = mem.write & ~mem.read & ~full & ~coal_write;
  assign pop        = (state == DRAIN) & ~dmem.busywait;
  assign wbuf_empty = empty & (state != DRAIN);

  always_comb begin
    mem.readdata = read_hit ? data_q[fwd_idx] : rdata_q;
    if (mem.read)
      mem.busywait = ~(read_hit | (state == RDONE));
    else
      mem.busywait = mem.write & full & ~coal_write;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)
        count <= count + (PTR_W+1)'(1);
      else if (pop && !push)
        count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_q[tail] <= mem.address;
      data_q[tail] <= mem.writedata;
    end
    if (coal_write) data_q[coal_idx] <= mem.writedata;
  end

  always_comb begin
    next_state  = state;
    start_read  = 1'b0;
    start_drain = 1'b0;
    read_done   = 1'b0;
    case (state)
      IDLE: begin
        if (mem.read && !fwd_hit) begin
          start_read = 1'b1;
          next_state = READ;
        end else if (!empty) begin
          start_drain = 1'b1;
          next_state  = DRAIN;
        end
      end
      DRAIN: if (!dmem.busywait) next_state = IDLE;
      READ: begin
        if (!dmem.busywait) begin
          read_done  = 1'b1;
          next_state = RDONE;
        end
      end
      RDONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      dmem.read      <= 1'b0;
      dmem.write     <= 1'b0;
      dmem.address   <= '0;
      dmem.writedata <= '0;
      rdata_q        <= '0;
    end else begin
      state <= next_state;
      if (start_read) begin
        dmem.read    <= 1'b1;
        dmem.address <= mem.address;
      end
      if (start_drain) begin
        dmem.write   <= 1'b1;
        dmem.address <= addr_q[head];
        // A coalesce landing on the head in the launch cycle must reach memory, not the stale copy.
        dmem.writedata <= (coal_write && coal_idx == head) ? mem.writedata : data_q[head];
      end
      if (pop) dmem.write <= 1'b0;
      if (read_done) begin
        dmem.read <= 1'b0;
        rdata_q   <= dmem.readdata;
      end
    end
  end
endmodule
